// File: rtl/mem_port_arbiter.sv
// Two-owner arbiter sharing one memory bus port between instruction fetch and load/store.
// Optional bus-wait timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [1:0]  grant_o,
  output logic        bus_err_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_IF = 2'd1;
  localparam logic [1:0] GRANT_D  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
    $error("MAX_D_STREAK out of range 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  state_q,  state_d;
  logic [3:0]  streak_q, streak_d;
  logic        cyc_q,    cyc_d;
  logic        we_q,     we_d;
  logic [3:0]  sel_q,    sel_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [1:0]  grant_q,  grant_d;

  logic        bus_done;
  logic        timeout_hit;
  logic        data_wins;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_q, wait_d;

  // A real ack in the timeout cycle wins, so the abort only fires without one.
  assign timeout_hit = cyc_q && !bus_ack_i && (wait_q == TIMEOUT_LIM);

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = 16'd0;
    end else if (!bus_ack_i && !timeout_hit && wait_q != 16'hFFFF) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_q <= 16'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Acks are suppressed during reset so an aborted transaction never completes.
  assign bus_done   = reset_n && cyc_q && (bus_ack_i || timeout_hit);
  assign if_ack_o   = bus_done && (state_q == GRANT_IF);
  assign d_ack_o    = bus_done && (state_q == GRANT_D);
  assign if_rdata_o = (if_ack_o && bus_ack_i) ? bus_rdata_i : 32'd0;
  assign d_rdata_o  = (d_ack_o  && bus_ack_i) ? bus_rdata_i : 32'd0;
  assign bus_err_o  = reset_n && timeout_hit;

  assign data_wins  = d_req_i && (!if_req_i || streak_q != STREAK_MAX);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d  = GRANT_D;
          cyc_d    = 1'b1;
          we_d     = d_we_i;
          sel_d    = d_sel_i;
          addr_d   = d_addr_i;
          wdata_d  = d_wdata_i;
          grant_d  = 2'b10;
          if (!if_req_i) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (if_req_i) begin
          state_d  = GRANT_IF;
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          sel_d    = 4'hF;
          addr_d   = if_addr_i;
          wdata_d  = 32'd0;
          grant_d  = 2'b01;
          streak_d = 4'd0;
        end
      end
      GRANT_IF, GRANT_D: begin
        // Attributes are held past completion; only the cycle strobe drops.
        if (bus_done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
    end
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout cases run when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [1:0]  grant_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .grant_o(grant_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 20 && !bus_cyc_o; i++) step();
    chk(tag, {31'd0, bus_cyc_o}, 32'd1);
  endtask

  // Serve one transaction with an immediate ack; returns the observed grant and acks.
  task automatic serve(input logic [31:0] rdata, output logic [1:0] g,
                       output logic ia, output logic da);
    wait_cyc("serve_cyc");
    g = grant_o;
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    #1;
    ia = if_ack_o;
    da = d_ack_o;
    step();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
  endtask

  logic [1:0] g;
  logic       ia, da;
  logic [1:0] exp_order [10];

  initial begin
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    reset_n = 1'b0; if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = 4'd0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    bus_rdata_i = 32'd0; bus_ack_i = 1'b0;

    // Reset then idle
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_cyc",   {31'd0, bus_cyc_o}, 32'd0);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_acks",  {30'd0, if_ack_o, d_ack_o}, 32'd0);
    chk("rst_addr",  bus_addr_o, 32'd0);
    chk("rst_attr",  {27'd0, bus_we_o, bus_sel_o}, 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_err",   {31'd0, bus_err_o}, 32'd0);

    // Fetch read, slave acks one cycle after bus_cyc_o rises
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    chk("if_cyc",   {31'd0, bus_cyc_o}, 32'd1);
    chk("if_grant", {30'd0, grant_o}, 32'd1);
    chk("if_addr",  bus_addr_o, 32'h100);
    chk("if_attr",  {27'd0, bus_we_o, bus_sel_o}, 32'h0F);
    chk("if_noack", {30'd0, if_ack_o, d_ack_o}, 32'd0);
    step();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    #1;
    chk("if_ack",   {31'd0, if_ack_o}, 32'd1);
    chk("if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("if_d_ack", {31'd0, d_ack_o}, 32'd0);
    chk("if_d_rd",  d_rdata_o, 32'd0);
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0; if_req_i = 1'b0;
    #1;
    chk("if_cyc_fall", {31'd0, bus_cyc_o}, 32'd0);
    chk("if_ack_gone", {31'd0, if_ack_o}, 32'd0);
    chk("if_addr_hold", bus_addr_o, 32'h100);

    // Both requesting and held: data streak then one fetch
    if_req_i = 1'b1; if_addr_i = 32'h200;
    d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      serve(32'hA0 + 32'(i), g, ia, da);
      chk($sformatf("order_%0d", i), {30'd0, g}, {30'd0, exp_order[i]});
      chk($sformatf("order_ack_%0d", i), {30'd0, da, ia}, {30'd0, exp_order[i]});
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    step();

    // Data write with a 5-cycle slave stall
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011;
    d_addr_i = 32'h2004; d_wdata_i = 32'h1234;
    wait_cyc("wr_cyc");
    chk("wr_grant", {30'd0, grant_o}, 32'd2);
    chk("wr_attr",  {27'd0, bus_we_o, bus_sel_o}, 32'h13);
    chk("wr_addr",  bus_addr_o, 32'h2004);
    chk("wr_wdata", bus_wdata_o, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wr_stall_ack_%0d", i), {31'd0, d_ack_o}, 32'd0);
      chk($sformatf("wr_stall_attr_%0d", i), {27'd0, bus_we_o, bus_sel_o}, 32'h13);
      chk($sformatf("wr_stall_addr_%0d", i), bus_addr_o, 32'h2004);
      chk($sformatf("wr_stall_wd_%0d", i), bus_wdata_o, 32'h1234);
    end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55;
    #1;
    chk("wr_ack",    {31'd0, d_ack_o}, 32'd1);
    chk("wr_rdata",  d_rdata_o, 32'h55);
    chk("wr_if_ack", {31'd0, if_ack_o}, 32'd0);
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0; d_req_i = 1'b0;
    #1;
    chk("wr_ack_single", {31'd0, d_ack_o}, 32'd0);
    chk("wr_cyc_fall",   {31'd0, bus_cyc_o}, 32'd0);
    chk("wr_attr_hold",  bus_addr_o, 32'h2004);

    // Reset during GRANT_D followed by a late slave ack
    step();
    d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h3000;
    wait_cyc("rstmid_cyc");
    reset_n = 1'b0;
    #1;
    chk("rstmid_noack_in_rst", {31'd0, d_ack_o}, 32'd0);
    step();
    reset_n = 1'b1; d_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h77;
    #1;
    chk("rstmid_late_ack", {31'd0, d_ack_o}, 32'd0);
    chk("rstmid_cyc",      {31'd0, bus_cyc_o}, 32'd0);
    chk("rstmid_grant",    {30'd0, grant_o}, 32'd0);
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    #1;
    chk("rstmid_idle",     {29'd0, bus_cyc_o, grant_o}, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Slave never acks: abort in the 9th grant cycle
    d_req_i = 1'b1; d_addr_i = 32'h4000;
    wait_cyc("to_cyc");
    d_req_i = 1'b0;
    bus_rdata_i = 32'hCAFEF00D;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_wait_ack_%0d", k), {30'd0, d_ack_o, bus_err_o}, 32'd0);
      step();
    end
    chk("to_ack",   {31'd0, d_ack_o}, 32'd1);
    chk("to_err",   {31'd0, bus_err_o}, 32'd1);
    chk("to_rdata", d_rdata_o, 32'd0);
    step();
    chk("to_cyc_fall", {31'd0, bus_cyc_o}, 32'd0);
    chk("to_err_fall", {31'd0, bus_err_o}, 32'd0);
    bus_rdata_i = 32'd0;

    // Ack coinciding with the timeout cycle completes normally
    step();
    d_req_i = 1'b1; d_addr_i = 32'h5000;
    wait_cyc("to2_cyc");
    d_req_i = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h600D;
    #1;
    chk("to2_ack",   {31'd0, d_ack_o}, 32'd1);
    chk("to2_err",   {31'd0, bus_err_o}, 32'd0);
    chk("to2_rdata", d_rdata_o, 32'h600D);
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    #1;
    chk("to2_cyc_fall", {31'd0, bus_cyc_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the core's single memory bus port between the instruction-fetch requester (IF1/IF2) and the load/store requester (EX/MEM).
- A registered two-owner state machine serialises the transactions.
- The fairness rule gives data access priority, but instruction fetch cannot starve.
- Acknowledges and read data return to the owning requester only, so the pipeline stall logic can use the ack signals directly.

## Interface
Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while fetch waits; then fetch wins once. Legal range 1..15.
- TIMEOUT_CYCLES, 255: bus cycles without `bus_ack_i` before abort (only with ARB_TIMEOUT_EN). Legal range 1..65535.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset_n  in  1  Reset is synchronous and active-low.
- if_req_i  in  1  Fetch request; held with `if_addr_i` stable until `if_ack_o`.
- if_addr_i  in  32  Fetch word address.
- if_ack_o  out  1  One-cycle completion pulse to fetch.
- if_rdata_o  out  32  Fetch read data; valid with `if_ack_o`.
- d_req_i  in  1  Data request; held with its attributes stable until `d_ack_o`.
- d_we_i  in  1  Data write enable.
- d_sel_i  in  4  Byte-lane select.
- d_addr_i  in  32  Data address.
- d_wdata_i  in  32  Store data.
- d_ack_o  out  1  One-cycle completion pulse to data.
- d_rdata_o  out  32  Load data; valid with `d_ack_o`.
- bus_cyc_o  out  1  Registered: a transaction is active.
- bus_we_o  out  1  Registered write enable.
- bus_sel_o  out  4  Registered byte-lane select.
- bus_addr_o  out  32  Registered address.
- bus_wdata_o  out  32  Registered write data.
- bus_rdata_i  in  32  Slave read data; valid with `bus_ack_i`.
- bus_ack_i  in  1  Slave completion; ignored while `bus_cyc_o` = 0.
- grant_o  out  2  One-hot owner {data, fetch}; 2'b00 when idle.
- bus_err_o  out  1  One-cycle timeout-abort flag, coincident with the owner's ack.

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_D.
- IDLE, one requester active: latch that requester's attributes into the bus registers and enter the matching GRANT state.
- IDLE, both requesting: data wins unless `d_streak` = MAX_D_STREAK; in that case fetch wins.
- `d_streak` counter:
  - Increments on each data grant made while `if_req_i` = 1.
  - Clears on any fetch grant.
  - Clears on a data grant made while `if_req_i` = 0.
  - Saturates at MAX_D_STREAK.
- In a GRANT state, with `bus_ack_i` = 1:
  - Pass `bus_ack_i` through combinationally to the owner's ack.
  - Pass `bus_rdata_i` through to the owner's rdata.
  - Next state is IDLE.
- For a fetch grant, `bus_we_o` = 0 and `bus_sel_o` = 4'hF.
- Ack outputs are always 0 for the non-owner.
- Rdata outputs are 0 whenever the corresponding ack is 0.
- IDLE always lasts at least one cycle between transactions, so requesters can drop or change their request.
- Reset mid-transaction:
  - Next state is IDLE; all counters clear.
  - A late `bus_ack_i` is ignored.
  - No ack is issued for the aborted transaction.

## Timing
- Reset values: `bus_cyc_o`, `bus_we_o`, `grant_o`, `bus_err_o`, both acks = 0; all data/address/sel outputs = 0; `d_streak` = 0; state IDLE.
- Latency: request sampled in IDLE at cycle N; `bus_cyc_o` and `grant_o` valid at N+1.
- Ack appears in the same cycle as `bus_ack_i`; the minimum is N+1.
- Peak throughput: one transaction per 2 cycles.
- Bus attributes stay constant from grant until the cycle after ack.
- `bus_cyc_o` falls in the cycle after `bus_ack_i`.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on grant and increments each GRANT cycle without `bus_ack_i`.
  - When the count reaches TIMEOUT_CYCLES, the owner receives a one-cycle ack with rdata = 0 and `bus_err_o` = 1, and the state returns to IDLE.
  - `bus_ack_i` arriving in the same cycle as the timeout takes precedence: normal completion, `bus_err_o` = 0.
- Undefined: no counter; `bus_err_o` is tied to 0; a GRANT state waits indefinitely.

## Test plan
- Reset then idle: all outputs 0. Fetch request at 0x100, slave acks 1 cycle after `bus_cyc_o` with 0xDEADBEEF: `if_ack_o` pulses, `if_rdata_o` = 0xDEADBEEF, `d_ack_o` = 0.
- Simultaneous requests, both held: grant order is D,D,D,D,IF,D,D,D,D,IF (MAX_D_STREAK = 4).
- Data write: addr 0x2004, sel 4'b0011, wdata 0x1234 → bus outputs match exactly; slave stalls 5 cycles; attributes stay stable; a single `d_ack_o` pulse.
- `reset_n` = 0 for one cycle while in GRANT_D, slave acks the next cycle: no `d_ack_o`; `bus_cyc_o` = 0; FSM in IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks: `d_ack_o` and `bus_err_o` pulse together in the 9th GRANT cycle (count reaches 8), with rdata = 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, ack arrives exactly at the timeout cycle: normal completion, `bus_err_o` = 0.
